mcif_wr_align_pipe: RTL and testbench

- Write-direction counterpart of the MCIF read-side alignment pipe.
- Takes a byte-packed write stream, starting at byte 0 of beat 0, plus a per-burst command with a destination byte offset and length.
- Emits AXI-width beats shifted to that offset, with per-byte write strobes and a last flag.
- Sits between the engine write-data FIFO and the AXI W channel; handles one burst at a time.

---
 rtl/mcif_wr_align_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_mcif_wr_align_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcif_wr_align_pipe.sv
// -----------------------------------------------------------------------------
// mcif_wr_align_pipe
//
// Write-direction alignment pipe between the engine write-data FIFO and the
// AXI W channel. A burst command supplies a destination byte offset and a byte
// length. The packed input stream starts at byte 0 of its first beat. Each
// input beat is shifted up by the offset, and the bytes that spill past the top
// of the beat are carried into the next output beat. Per-byte strobes and a
// last flag are generated. One burst is handled at a time.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_vld/rdy     burst command handshake
//   cmd_offset      destination byte offset within the first output beat
//   cmd_len         burst length in bytes (0 = no beats emitted)
//   data_in_*       packed input beat stream (valid/ready)
//   data_out_*      aligned output beat, strobes and last (valid/ready)
//   busy            high whenever a burst is being processed
// -----------------------------------------------------------------------------
module mcif_wr_align_pipe #(
   parameter int DW   = 256,
   parameter int BW   = DW / 8,
   parameter int OFFW = $clog2(BW),
   parameter int LENW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_vld,
   output logic            cmd_rdy,
   input  logic [OFFW-1:0] cmd_offset,
   input  logic [LENW-1:0] cmd_len,
   input  logic            data_in_vld,
   input  logic [DW-1:0]   data_in,
   output logic            data_in_rdy,
   output logic            data_out_vld,
   output logic [DW-1:0]   data_out,
   output logic [BW-1:0]   data_out_strb,
   output logic            data_out_last,
   input  logic            data_out_rdy,
   output logic            busy
);

   // Beat counters need one bit more than the length field: offset + length
   // can exceed the LENW range before it is divided down to beats.
   localparam int CNTW = LENW + 1;
   // Shift amounts are byte counts times 8, up to DW inclusive.
   localparam int SHW  = OFFW + 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [OFFW-1:0]   off_reg, off_next;
   logic [OFFW-1:0]   end_reg, end_next;      // (offset + length) mod BW
   logic [CNTW-1:0]   nin_reg, nin_next;
   logic [CNTW-1:0]   nout_reg, nout_next;
   logic [CNTW-1:0]   in_cnt_reg, in_cnt_next;
   logic [DW-1:0]     residue_reg, residue_next;
   logic [DW-1:0]     out_data_reg, out_data_next;
   logic [BW-1:0]     out_strb_reg, out_strb_next;
   logic              out_vld_reg, out_vld_next;
   logic              out_last_reg, out_last_next;

   // ---------------------------------------------------------------------------
   // Command-time arithmetic
   // ---------------------------------------------------------------------------
   logic [CNTW-1:0]   len_ext;
   logic [CNTW-1:0]   sum_ext;
   logic [CNTW-1:0]   nin_calc;
   logic [CNTW-1:0]   nout_calc;

   assign len_ext   = CNTW'(cmd_len);
   assign sum_ext   = len_ext + CNTW'(cmd_offset);
   assign nin_calc  = (len_ext + CNTW'(BW - 1)) >> OFFW;
   assign nout_calc = (sum_ext + CNTW'(BW - 1)) >> OFFW;

   // ---------------------------------------------------------------------------
   // Handshake qualifiers
   // ---------------------------------------------------------------------------
   logic out_free;     // output register can take a new beat this cycle
   logic in_fire;
   logic flush_fire;

   assign out_free   = !out_vld_reg || data_out_rdy;
   assign in_fire    = (state_reg == ST_RUN) && data_in_vld && out_free;
   assign flush_fire = (state_reg == ST_FLUSH) && out_free;

   // ---------------------------------------------------------------------------
   // Strobe generation for the beat being loaded. In RUN the output beat index
   // equals the input beat index; the FLUSH beat is always the final one.
   // ---------------------------------------------------------------------------
   logic [BW-1:0] ones;
   logic [BW-1:0] first_mask;
   logic [BW-1:0] last_mask;
   logic          beat_first;
   logic          beat_last;
   logic [BW-1:0] strb_calc;

   assign ones       = '1;
   assign first_mask = ones << off_reg;
   assign last_mask  = (end_reg == '0) ? ones : ~(ones << end_reg);
   assign beat_first = (state_reg == ST_RUN) && (in_cnt_reg == '0);
   assign beat_last  = (state_reg == ST_FLUSH) ||
                       (in_cnt_reg == (nout_reg - CNTW'(1)));
   assign strb_calc  = (beat_first ? first_mask : ones) &
                       (beat_last  ? last_mask  : ones);

   // Byte-lane expansion of the strobe so unstrobed bytes are forced to zero.
   logic [DW-1:0] byte_mask;

   generate
      for (genvar gi = 0; gi < BW; gi++) begin : g_byte_mask
         assign byte_mask[8*gi +: 8] = {8{strb_calc[gi]}};
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Shifter. The left shift places the input at the offset; the right shift
   // keeps the top OFF bytes for the next beat. With OFF=0 the right shift
   // would be a full-width shift, so the residue is forced to zero instead.
   // ---------------------------------------------------------------------------
   logic [SHW-1:0] lsh;
   logic [SHW-1:0] rsh;
   logic [DW-1:0]  shifted;
   logic [DW-1:0]  residue_calc;
   logic [DW-1:0]  load_raw;

   assign lsh          = SHW'({off_reg, 3'b000});
   assign rsh          = SHW'(DW) - lsh;
   assign shifted      = (data_in << lsh) | residue_reg;
   assign residue_calc = (off_reg == '0) ? '0 : (data_in >> rsh);
   assign load_raw     = in_fire ? shifted : residue_reg;

   // ---------------------------------------------------------------------------
   // Next-state / datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      off_next      = off_reg;
      end_next      = end_reg;
      nin_next      = nin_reg;
      nout_next     = nout_reg;
      in_cnt_next   = in_cnt_reg;
      residue_next  = residue_reg;
      out_data_next = out_data_reg;
      out_strb_next = out_strb_reg;
      out_vld_next  = out_vld_reg;
      out_last_next = out_last_reg;

      // Drain the output register on handshake; a load below overrides this.
      if (out_vld_reg && data_out_rdy) begin
         out_vld_next  = 1'b0;
         out_last_next = 1'b0;
      end

      unique case (state_reg)
         ST_IDLE: begin
            if (cmd_vld) begin
               off_next     = cmd_offset;
               end_next     = sum_ext[OFFW-1:0];
               nin_next     = nin_calc;
               nout_next    = nout_calc;
               in_cnt_next  = '0;
               residue_next = '0;
               state_next   = (cmd_len == '0) ? ST_DONE : ST_RUN;
            end
         end

         ST_RUN: begin
            if (in_fire) begin
               out_data_next = load_raw & byte_mask;
               out_strb_next = strb_calc;
               out_vld_next  = 1'b1;
               out_last_next = beat_last;
               residue_next  = residue_calc;
               in_cnt_next   = in_cnt_reg + CNTW'(1);
               if (in_cnt_reg == (nin_reg - CNTW'(1))) begin
                  state_next = (nout_reg > nin_reg) ? ST_FLUSH : ST_DONE;
               end
            end
         end

         ST_FLUSH: begin
            if (flush_fire) begin
               out_data_next = load_raw & byte_mask;
               out_strb_next = strb_calc;
               out_vld_next  = 1'b1;
               out_last_next = 1'b1;
               state_next    = ST_DONE;
            end
         end

         ST_DONE: begin
            // Leave once the final beat is gone (or was never produced).
            if (out_free) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         off_reg      <= '0;
         end_reg      <= '0;
         nin_reg      <= '0;
         nout_reg     <= '0;
         in_cnt_reg   <= '0;
         residue_reg  <= '0;
         out_data_reg <= '0;
         out_strb_reg <= '0;
         out_vld_reg  <= 1'b0;
         out_last_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         off_reg      <= off_next;
         end_reg      <= end_next;
         nin_reg      <= nin_next;
         nout_reg     <= nout_next;
         in_cnt_reg   <= in_cnt_next;
         residue_reg  <= residue_next;
         out_data_reg <= out_data_next;
         out_strb_reg <= out_strb_next;
         out_vld_reg  <= out_vld_next;
         out_last_reg <= out_last_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cmd_rdy       = (state_reg == ST_IDLE);
   assign busy          = (state_reg != ST_IDLE);
   assign data_in_rdy   = (state_reg == ST_RUN) && out_free;
   assign data_out_vld  = out_vld_reg;
   assign data_out      = out_data_reg;
   assign data_out_strb = out_strb_reg;
   assign data_out_last = out_last_reg;

endmodule

// File: tb/tb_mcif_wr_align_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for mcif_wr_align_pipe (DW=32, BW=4).
// Directed table vectors, a reset-in-flight sequence and randomized bursts
// checked against a byte-position reference model.
// -----------------------------------------------------------------------------
module tb_mcif_wr_align_pipe;

   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int OFFW = 2;
   localparam int LENW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_vld;
   logic            cmd_rdy;
   logic [OFFW-1:0] cmd_offset;
   logic [LENW-1:0] cmd_len;
   logic            data_in_vld;
   logic [DW-1:0]   data_in;
   logic            data_in_rdy;
   logic            data_out_vld;
   logic [DW-1:0]   data_out;
   logic [BW-1:0]   data_out_strb;
   logic            data_out_last;
   logic            data_out_rdy;
   logic            busy;

   always #5 clk = ~clk;

   mcif_wr_align_pipe #(.DW(DW), .BW(BW), .OFFW(OFFW), .LENW(LENW)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_vld       (cmd_vld),
      .cmd_rdy       (cmd_rdy),
      .cmd_offset    (cmd_offset),
      .cmd_len       (cmd_len),
      .data_in_vld   (data_in_vld),
      .data_in       (data_in),
      .data_in_rdy   (data_in_rdy),
      .data_out_vld  (data_out_vld),
      .data_out      (data_out),
      .data_out_strb (data_out_strb),
      .data_out_last (data_out_last),
      .data_out_rdy  (data_out_rdy),
      .busy          (busy)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          mode;   // 0: rdy always 1, 1: rdy 1010..., 2: random
      int          off;
      int          len;
      int          n;      // expected output beats
      logic [31:0] in0, in1;
      logic [31:0] d0;  logic [3:0] s0;
      logic [31:0] d1;  logic [3:0] s1;
      logic [31:0] d2;  logic [3:0] s2;
   } vec_t;

   vec_t tbl[6];

   logic [31:0] in_beats[$];
   logic [7:0]  src_bytes[$];
   logic [31:0] got_d[$];
   logic [3:0]  got_s[$];
   logic        got_l[$];
   logic [31:0] exp_d[$];
   logic [3:0]  exp_s[$];
   logic        exp_l[$];
   int          consumed, lat_in, lat_out, end_cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Drives one burst: command, input beats (garbage beyond NIN kept valid),
   // output ready pattern; collects handshaked output beats.
   task automatic run_burst(input int off, input int len, input int mode);
      int  nin;
      int  cyc;
      bit  hold;
      bit  done;
      logic [31:0] hd;
      logic [3:0]  hs;
      logic        hl;
      got_d.delete(); got_s.delete(); got_l.delete();
      consumed = 0; lat_in = -1; lat_out = -1; end_cyc = -1;
      nin = (len + 3) / 4;
      @(negedge clk);
      data_in_vld = 1'b0;
      cyc = 0;
      while (!cmd_rdy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!cmd_rdy) begin
         chk("cmd_rdy_wait", cmd_rdy, 1);
         return;
      end
      cmd_vld    = 1'b1;
      cmd_offset = off[OFFW-1:0];
      cmd_len    = len[LENW-1:0];
      @(negedge clk);
      cmd_vld = 1'b0;
      hold = 0; done = 0; hd = '0; hs = '0; hl = 1'b0;
      for (cyc = 0; cyc < 200 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         case (mode)
            0:       data_out_rdy = 1'b1;
            1:       data_out_rdy = (cyc % 2 == 0);
            default: data_out_rdy = 1'($urandom_range(0, 1));
         endcase
         data_in_vld = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         data_in     = (consumed < nin) ? in_beats[consumed] : $urandom();
         #1;
         if (hold) begin
            chk("hold_data", data_out, hd);
            chk("hold_strb", data_out_strb, hs);
            chk("hold_last", data_out_last, hl);
         end
         if (data_out_vld && lat_out < 0) lat_out = cyc;
         if (data_out_vld && data_out_rdy) begin
            got_d.push_back(data_out);
            got_s.push_back(data_out_strb);
            got_l.push_back(data_out_last);
         end
         hold = data_out_vld && !data_out_rdy;
         hd = data_out; hs = data_out_strb; hl = data_out_last;
         if (data_in_vld && data_in_rdy) begin
            if (lat_in < 0) lat_in = cyc;
            consumed++;
         end
         if (!busy) begin
            done = 1;
            end_cyc = cyc;
         end
      end
      if (!done) chk("burst_timeout", busy, 0);
      data_in_vld  = 1'b0;
      data_out_rdy = 1'b1;
      chk("consumed_beats", consumed, nin);
      $display("burst off=%0d len=%0d mode=%0d in=%0d out=%0d", off, len, mode, consumed, got_d.size());
   endtask

   task automatic compare_outputs();
      int n;
      chk("beat_count", got_d.size(), exp_d.size());
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         chk("beat_data", got_d[i], exp_d[i]);
         chk("beat_strb", got_s[i], exp_s[i]);
         chk("beat_last", got_l[i], exp_l[i]);
      end
   endtask

   task automatic run_vector(input int i);
      int nin;
      nin = (tbl[i].len + 3) / 4;
      in_beats.delete();
      if (nin > 0) in_beats.push_back(tbl[i].in0);
      if (nin > 1) in_beats.push_back(tbl[i].in1);
      exp_d.delete(); exp_s.delete(); exp_l.delete();
      if (tbl[i].n > 0) begin exp_d.push_back(tbl[i].d0); exp_s.push_back(tbl[i].s0); exp_l.push_back(tbl[i].n == 1); end
      if (tbl[i].n > 1) begin exp_d.push_back(tbl[i].d1); exp_s.push_back(tbl[i].s1); exp_l.push_back(tbl[i].n == 2); end
      if (tbl[i].n > 2) begin exp_d.push_back(tbl[i].d2); exp_s.push_back(tbl[i].s2); exp_l.push_back(1'b1); end
      run_burst(tbl[i].off, tbl[i].len, tbl[i].mode);
      compare_outputs();
      if (tbl[i].mode == 0 && tbl[i].len > 0) chk("first_beat_latency", lat_out - lat_in, 1);
      if (tbl[i].len == 0) chk("len0_cmd_rdy_within_2", (end_cyc >= 0 && end_cyc <= 2), 1);
   endtask

   // Reference model: the burst occupies destination byte positions
   // [off, off+len) of a byte stream cut into BW-byte beats.
   task automatic build_random(input int off, input int len);
      int nin, nout, p;
      logic [31:0] d;
      logic [3:0]  s;
      src_bytes.delete(); in_beats.delete();
      exp_d.delete(); exp_s.delete(); exp_l.delete();
      for (int i = 0; i < len; i++) src_bytes.push_back(8'($urandom()));
      nin  = (len + 3) / 4;
      nout = (len == 0) ? 0 : (off + len + 3) / 4;
      for (int b = 0; b < nin; b++) begin
         d = '0;
         for (int ln = 0; ln < 4; ln++)
            d[8*ln +: 8] = (b*4 + ln < len) ? src_bytes[b*4 + ln] : 8'($urandom());
         in_beats.push_back(d);
      end
      for (int k = 0; k < nout; k++) begin
         d = '0; s = '0;
         for (int ln = 0; ln < 4; ln++) begin
            p = k*4 + ln;
            if (p >= off && p < off + len) begin
               d[8*ln +: 8] = src_bytes[p - off];
               s[ln] = 1'b1;
            end
         end
         exp_d.push_back(d); exp_s.push_back(s); exp_l.push_back(k == nout - 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int off, len, mode;
      tbl[0] = '{0, 0, 8, 2, 32'h44332211, 32'h88776655,
                 32'h44332211, 4'hF, 32'h88776655, 4'hF, 32'h0, 4'h0};
      tbl[1] = '{0, 1, 6, 2, 32'h44332211, 32'h00006655,
                 32'h33221100, 4'hE, 32'h00665544, 4'h7, 32'h0, 4'h0};
      tbl[2] = '{0, 3, 6, 3, 32'h44332211, 32'h00006655,
                 32'h11000000, 4'h8, 32'h55443322, 4'hF, 32'h00000066, 4'h1};
      tbl[3] = '{0, 2, 1, 1, 32'h000000AA, 32'h0,
                 32'h00AA0000, 4'h4, 32'h0, 4'h0, 32'h0, 4'h0};
      tbl[4] = '{0, 1, 0, 0, 32'h0, 32'h0,
                 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0};
      tbl[5] = '{1, 3, 6, 3, 32'h44332211, 32'h00006655,
                 32'h11000000, 4'h8, 32'h55443322, 4'hF, 32'h00000066, 4'h1};

      rst = 1'b1; cmd_vld = 1'b0; cmd_offset = '0; cmd_len = '0;
      data_in_vld = 1'b0; data_in = '0; data_out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_cmd_rdy", cmd_rdy, 1);
      chk("reset_busy", busy, 0);
      chk("reset_out_vld", data_out_vld, 0);
      chk("reset_out_last", data_out_last, 0);
      chk("reset_in_rdy", data_in_rdy, 0);
      chk("reset_data", data_out, 0);
      chk("reset_strb", data_out_strb, 0);

      for (int i = 0; i < 6; i++) run_vector(i);

      // Reset in the cycle after beat 1 of an OFF=3 burst.
      @(negedge clk);
      cmd_vld = 1'b1; cmd_offset = 2'd3; cmd_len = 16'd6; data_in_vld = 1'b0;
      @(negedge clk);
      cmd_vld = 1'b0; data_in_vld = 1'b1; data_in = 32'h44332211; data_out_rdy = 1'b1;
      #1;
      chk("rstseq_in_rdy", data_in_rdy, 1);
      @(negedge clk);
      data_in_vld = 1'b0; rst = 1'b1;
      #1;
      chk("rstseq_beat1_vld", data_out_vld, 1);
      chk("rstseq_beat1_data", data_out, 32'h11000000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstseq_out_vld", data_out_vld, 0);
      chk("rstseq_busy", busy, 0);
      chk("rstseq_cmd_rdy", cmd_rdy, 1);
      run_vector(1);

      // Randomized bursts against the byte-position model.
      for (int t = 0; t < 40; t++) begin
         off  = $urandom_range(0, 3);
         len  = (t < 4) ? t : $urandom_range(0, 20);
         mode = $urandom_range(0, 2);
         build_random(off, len);
         run_burst(off, len, mode);
         compare_outputs();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
